// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: pops bytes from the receiver, decodes E0/F0 prefixes,
// follows the most recently pressed key and counts distinct presses.
module ps2_key_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_ready,
  input  logic [7:0]       rx_data,
  output logic             rx_pop,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_valid,
  output logic [CNT_W-1:0] press_cnt,
  output logic             press_pulse
);

  localparam logic [7:0] CODE_EXT  = 8'hE0;
  localparam logic [7:0] CODE_BRK  = 8'hF0;
  localparam logic [7:0] CODE_ERR0 = 8'h00;
  localparam logic [7:0] CODE_ERR1 = 8'hFF;
  localparam logic [7:0] CODE_BAT  = 8'hAA;

  logic gap;
  logic brk_flag;
  logic ext_flag;
  logic same_key;

  // The idle cycle after each pop gives the receiver time to present its next byte.
  assign rx_pop   = rx_ready & ~gap;
  assign same_key = key_valid && (rx_data == key_code) && (ext_flag == key_ext);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gap         <= 1'b0;
      brk_flag    <= 1'b0;
      ext_flag    <= 1'b0;
      key_code    <= 8'h00;
      key_ext     <= 1'b0;
      key_valid   <= 1'b0;
      press_cnt   <= '0;
      press_pulse <= 1'b0;
    end else begin
      gap         <= rx_pop;
      press_pulse <= 1'b0;
      if (rx_pop) begin
        case (rx_data)
          CODE_EXT: ext_flag <= 1'b1;
          CODE_BRK: brk_flag <= 1'b1;
          CODE_ERR0, CODE_ERR1, CODE_BAT: begin
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
          end
          default: begin
            // A break only releases the tracked key; a make of the held key is typematic.
            if (brk_flag) begin
              if (same_key) key_valid <= 1'b0;
            end else if (!same_key) begin
              key_code    <= rx_data;
              key_ext     <= ext_flag;
              key_valid   <= 1'b1;
              press_cnt   <= press_cnt + 1'b1;
              press_pulse <= 1'b1;
            end
            brk_flag <= 1'b0;
            ext_flag <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: a queued receiver feeds both a 16-bit
// and a 4-bit counter instance, compared each cycle against a keyboard-level model.
module tb_ps2_key_tracker;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        rx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;

  logic        rx_pop, key_ext, key_valid, press_pulse;
  logic [7:0]  key_code;
  logic [15:0] press_cnt;

  logic        rx_pop4, key_ext4, key_valid4, press_pulse4;
  logic [7:0]  key_code4;
  logic [3:0]  press_cnt4;

  ps2_key_tracker #(.CNT_W(16)) u_dut (
    .clk(clk), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_pop(rx_pop), .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid),
    .press_cnt(press_cnt), .press_pulse(press_pulse)
  );

  ps2_key_tracker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .resetn(resetn), .rx_ready(rx_ready), .rx_data(rx_data),
    .rx_pop(rx_pop4), .key_code(key_code4), .key_ext(key_ext4), .key_valid(key_valid4),
    .press_cnt(press_cnt4), .press_pulse(press_pulse4)
  );

  always #5 clk = ~clk;

  // Receiver contents and keyboard-level model
  byte_q_t     q;
  int          stall_pct = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [7:0]  m_code;
  logic        m_ext, m_valid, m_pulse, m_gap;
  logic        pend_ext, pend_brk;
  int unsigned m_cnt;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_code = 8'h00; m_ext = 1'b0; m_valid = 1'b0; m_pulse = 1'b0; m_gap = 1'b0;
    pend_ext = 1'b0; pend_brk = 1'b0; m_cnt = 0;
  endtask

  // What the keyboard meant by this byte, in terms of held key and press count
  task automatic modelByte(input logic [7:0] b);
    bit is_held;
    if (b == 8'hE0) pend_ext = 1'b1;
    else if (b == 8'hF0) pend_brk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF || b == 8'hAA) begin
      pend_ext = 1'b0; pend_brk = 1'b0;
    end else begin
      is_held = m_valid && (b == m_code) && (pend_ext == m_ext);
      if (pend_brk) begin
        if (is_held) m_valid = 1'b0;
      end else if (!is_held) begin
        m_code = b; m_ext = pend_ext; m_valid = 1'b1;
        m_cnt = m_cnt + 1; m_pulse = 1'b1;
      end
      pend_ext = 1'b0; pend_brk = 1'b0;
    end
  endtask

  task automatic checkAll();
    checkOutput("key_code", 32'(key_code), 32'(m_code));
    checkOutput("key_ext", 32'(key_ext), 32'(m_ext));
    checkOutput("key_valid", 32'(key_valid), 32'(m_valid));
    checkOutput("press_cnt", 32'(press_cnt), m_cnt % 65536);
    checkOutput("press_pulse", 32'(press_pulse), 32'(m_pulse));
    checkOutput("key_code4", 32'(key_code4), 32'(m_code));
    checkOutput("press_cnt4", 32'(press_cnt4), m_cnt % 16);
    checkOutput("press_pulse4", 32'(press_pulse4), 32'(m_pulse));
  endtask

  // One clock: present the head byte, check the pop decision, then the registered results
  task automatic cycle();
    logic       exp_pop;
    logic [7:0] b;
    rx_ready = (q.size() > 0) && ($urandom_range(99) >= stall_pct);
    rx_data  = rx_ready ? q[0] : 8'($urandom);
    #1;
    exp_pop = rx_ready && !m_gap;
    checkOutput("rx_pop", 32'(rx_pop), 32'(exp_pop));
    checkOutput("rx_pop4", 32'(rx_pop4), 32'(exp_pop));
    @(posedge clk);
    #1;
    m_pulse = 1'b0;
    if (exp_pop) begin
      b = q.pop_front();
      n_pops++;
      modelByte(b);
    end
    m_gap = exp_pop;
    checkAll();
  endtask

  task automatic applyStimulus(input byte_q_t bytes, input int stall);
    int cyc = 0;
    stall_pct = stall;
    foreach (bytes[i]) q.push_back(bytes[i]);
    while ((q.size() > 0 || m_gap) && cyc < 2000) begin
      cycle();
      cyc++;
    end
    checkOutput("drain", 32'(q.size()), 32'd0);
    q.delete();
    cycle();
    cycle();
  endtask

  task automatic pulseReset();
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("rst_key_code", 32'(key_code), 32'd0);
    checkOutput("rst_key_ext", 32'(key_ext), 32'd0);
    checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_press_cnt", 32'(press_cnt), 32'd0);
    checkOutput("rst_press_pulse", 32'(press_pulse), 32'd0);
    checkOutput("rst_press_cnt4", 32'(press_cnt4), 32'd0);
    checkOutput("rst_rx_pop", 32'(rx_pop), 32'd0);
    #1;
    resetn = 1'b1;
    modelReset();
  endtask

  initial begin
    byte_q_t rnd;
    logic [7:0] pool [0:8];
    pool = '{8'h1C, 8'h32, 8'h75, 8'hE0, 8'hF0, 8'hF0, 8'h00, 8'hAA, 8'hFF};
    modelReset();
    #1;
    resetn = 1'b0;
    #2;
    checkOutput("reset_key_code", 32'(key_code), 32'd0);
    checkOutput("reset_key_valid", 32'(key_valid), 32'd0);
    checkOutput("reset_press_cnt", 32'(press_cnt), 32'd0);
    checkOutput("reset_rx_pop", 32'(rx_pop), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    $display("[TB] single press");
    applyStimulus('{8'h1C}, 0);
    checkOutput("single_cnt", 32'(press_cnt), 32'd1);
    $display("[TB] typematic and release");
    applyStimulus('{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C}, 20);
    checkOutput("typematic_cnt", 32'(press_cnt), 32'd1);
    checkOutput("typematic_valid", 32'(key_valid), 32'd0);
    checkOutput("typematic_code", 32'(key_code), 32'h1C);
    $display("[TB] extended keys");
    applyStimulus('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75}, 0);
    checkOutput("ext_code", 32'(key_code), 32'h75);
    checkOutput("ext_flag", 32'(key_ext), 32'd1);
    checkOutput("ext_valid", 32'(key_valid), 32'd0);
    applyStimulus('{8'hE0, 8'h75, 8'hF0, 8'h75}, 0);
    checkOutput("ext_plain_break_valid", 32'(key_valid), 32'd1);
    $display("[TB] overlapping presses with noise");
    applyStimulus('{8'h00, 8'h1C, 8'hAA, 8'h32, 8'hF0, 8'h1C, 8'h00, 8'hF0, 8'hAA, 8'h32}, 30);
    checkOutput("overlap_code", 32'(key_code), 32'h32);
    $display("[TB] back-to-back queue");
    n_pops = 0;
    applyStimulus('{8'h15, 8'hF0, 8'h15, 8'h24, 8'hF0, 8'h24}, 0);
    checkOutput("queue_pops", 32'(n_pops), 32'd6);
    $display("[TB] reset after break prefix");
    applyStimulus('{8'h1C, 8'hF0}, 0);
    pulseReset();
    applyStimulus('{8'h1C}, 0);
    checkOutput("post_reset_valid", 32'(key_valid), 32'd1);
    checkOutput("post_reset_cnt", 32'(press_cnt), 32'd1);
    $display("[TB] random byte stream");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) rnd.push_back(8'($urandom));
      else rnd.push_back(pool[$urandom_range(8)]);
    end
    applyStimulus(rnd, 30);
    $display("[TB] counter wrap");
    pulseReset();
    for (int i = 0; i < 17; i++) begin
      if (i % 2 == 0) applyStimulus('{8'h1C, 8'hF0, 8'h1C}, 10);
      else applyStimulus('{8'h32, 8'hF0, 8'h32}, 10);
      if (i == 14) checkOutput("wrap_15", 32'(press_cnt4), 32'd15);
      if (i == 15) checkOutput("wrap_0", 32'(press_cnt4), 32'd0);
    end
    checkOutput("wrap_1", 32'(press_cnt4), 32'd1);
    checkOutput("wrap_wide", 32'(press_cnt), 32'd17);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
